// File: rtl/lsu_sub_word.sv
// lsu_sub_word: multi-cycle load/store unit in front of a word-only data memory.
// Byte/halfword/word requests become word accesses; sub-word stores are done
// as read-modify-write, loads are sign- or zero-extended, and misaligned or
// illegal requests finish as faults without touching memory.
module lsu_sub_word #(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             wr,
    input  logic [1:0]       size,
    input  logic             uns,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [31:0]      rdata,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    input  logic [31:0]      dm_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t               state_q, state_d;
    logic [DM_AW+1:0]     addr_q;
    logic [31:0]          wdata_q;
    logic                 wr_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [31:0]          rd_q;      // word read during READ, used for the merge
    logic [31:0]          rdata_q;

    logic                 bad_req;
    logic [31:0]          merged;
    logic [31:0]          load_val;
    logic [7:0]           byte_val;
    logic [15:0]          half_val;

    // Address bits above the 4 KB window are ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:DM_AW+2];

    // Reject illegal sizes and misaligned half/word accesses at request time.
    always_comb begin
        unique case (size)
            SZ_BYTE: bad_req = 1'b0;
            SZ_HALF: bad_req = addr[0];
            SZ_WORD: bad_req = (addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    // State register.
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from the values of the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (bad_req)                    state_d = S_FAULT;
                    else if (wr && size == SZ_WORD) state_d = S_WRITE;
                    else                            state_d = S_READ;
                end
            end
            S_READ:  state_d = wr_q ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, read-word register and registered load result.
    // NOTE: all datapath registers are reset as well, so dm_addr, dm_din and
    // rdata come out of reset at a known zero rather than X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_IDLE && req) begin
                addr_q  <= addr[DM_AW+1:0];
                wdata_q <= wdata;
                wr_q    <= wr;
                size_q  <= size;
                uns_q   <= uns;
            end
            if (state_q == S_READ) begin
                rd_q <= dm_dout;
                if (!wr_q) rdata_q <= load_val;
            end
        end
    end

    // Lane extraction and extension of the word coming back from memory.
    always_comb begin
        byte_val = dm_dout[{addr_q[1:0], 3'b000} +: 8];
        half_val = dm_dout[{addr_q[1], 4'b0000} +: 16];
        unique case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: load_val = uns_q ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_val = dm_dout;
        endcase
    end

    // Store data: the read word with the addressed lane replaced, or the full
    // store word for word stores.
    always_comb begin
        merged = rd_q;
        unique case (size_q)
            SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // dm_we is decoded from the state alone, so an asynchronous reset during
    // WRITE removes it immediately.
    assign dm_addr = addr_q[DM_AW+1:2];
    assign dm_din  = merged;
    assign dm_we   = (state_q == S_WRITE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE) || (state_q == S_FAULT);
    assign fault   = (state_q == S_FAULT);
    assign rdata   = rdata_q;

endmodule

// File: doc/lsu_sub_word.md
Name: lsu_sub_word

Overview:
- Multi-cycle load/store unit placed directly upstream of the 4 KB word-addressed data memory.
- Converts CPU byte, halfword and word load/store requests into word-only memory accesses.
- Sub-word stores are done as read-modify-write, because the memory has word write enable only.
- Loads are sign- or zero-extended. Misaligned and illegal accesses are reported as faults without touching memory.

Parameters:
DM_AW, 10, word-address width driven to the memory (byte address bits [DM_AW+1:2]).

Ports:
clk      in   1   clock, rising edge
rst      in   1   asynchronous, active-low reset
req      in   1   request strobe, sampled only in IDLE
wr       in   1   1 = store, 0 = load
size     in   2   00 byte, 01 half, 10 word, 11 illegal
uns      in   1   1 = zero-extend load (ignored for word loads and for stores)
addr     in   32  byte address; only bits [DM_AW+1:0] used
wdata    in   32  store data, right-justified
busy     out  1   state != IDLE
done     out  1   one-cycle completion pulse
fault    out  1   qualifies done: access rejected
rdata    out  32  load result, registered, held until the next load completes
dm_addr  out  DM_AW  word address to memory
dm_din   out  32  write data to memory
dm_we    out  1   memory write enable
dm_dout  in   32  combinational read data from memory

Behaviour:
- Lane ordering is little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane = addr[1]: 0 selects [15:0], 1 selects [31:16].
- Reset (rst low, asynchronous):
  - state = IDLE.
  - busy, done, fault and dm_we = 0; rdata = 0.
  - Captured addr/wdata/op registers and the read-data register = 0, so dm_addr = 0 and dm_din = 0.
  - If rst is asserted during WRITE, dm_we drops immediately, so no memory write occurs at the next edge.
- States: IDLE, READ, WRITE, DONE, FAULT.
- IDLE, on a clock edge with req = 1:
  - Capture addr, wdata, wr, size and uns.
  - Go to FAULT if any of these hold:
    - size = 11;
    - size = 01 and addr[0] = 1;
    - size = 10 and addr[1:0] != 00.
  - Otherwise go to WRITE for a word store (wr = 1, size = 10).
  - Otherwise go to READ.
  - req = 0 keeps the unit in IDLE.
- req is ignored in every state other than IDLE; the CPU holds off until done. There is no queueing.
- READ:
  - dm_addr = captured addr[DM_AW+1:2].
  - At the edge, register dm_dout into the read-data register.
  - Next state: DONE for a load, WRITE for a sub-word store.
- WRITE:
  - dm_we = 1 for exactly this one cycle.
  - Word store: dm_din = wdata.
  - Byte store: dm_din = read word with lane k replaced by wdata[7:0].
  - Half store: dm_din = read word with the selected half replaced by wdata[15:0].
  - Next state: DONE.
- DONE:
  - done = 1 for one cycle.
  - For loads, rdata is updated at the READ→DONE edge.
  - Byte and half loads: extract the addressed lane, then sign-extend (uns = 0) or zero-extend (uns = 1).
  - Word load: rdata = full word.
  - Next state: IDLE.
- FAULT:
  - done = 1 and fault = 1 for one cycle.
  - dm_we stays 0 and rdata is unchanged.
  - Next state: IDLE.
- Latency, counted from the req-sampling edge to the cycle in which done is high:
  - Any load: 2 cycles.
  - Word store: 2 cycles.
  - Byte or half store: 3 cycles.
  - Fault: 1 cycle.
- Throughput: a new req is sampled no earlier than the edge ending DONE/FAULT, so the minimum spacing between requests is latency + 1 cycles.
- dm_we is never high outside WRITE. fault is never high without done.
- Stores and faults leave rdata unchanged.
- Addresses wrap modulo 4 KB; upper address bits are ignored.

Test Plan:
- Post-reset initial memory (all words 0x00000001):
  - LW 0x000 → done 2 cycles after req, rdata = 0x00000001.
  - LB 0x001 → rdata = 0x00000000.
- SB wdata = 0x000000_80 to 0x005, then LW 0x004 → 0x00008001.
  - Store done is 3 cycles after req; dm_we is high for exactly 1 cycle.
  - LB 0x005 → 0xFFFFFF80; LBU 0x005 → 0x00000080.
- SH wdata = 0x0000BEEF to 0x00A, then LW 0x008 → 0xBEEF0001; LH 0x00A → 0xFFFFBEEF; LHU 0x00A → 0x0000BEEF.
- SW 0xDEADBEEF to 0x010 → done 2 cycles after req with no READ cycle; LW 0x010 → 0xDEADBEEF.
- Faults, each giving done = fault = 1 one cycle after req, dm_we never high, rdata unchanged:
  - LW 0x002;
  - SH 0x003;
  - size = 11.
- Reset and busy handling:
  - Assert rst low mid-cycle during WRITE of an SB → dm_we falls immediately, memory word unchanged; all outputs 0 after reset.
  - Pulse req while busy → ignored, with no extra done.
